// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch, instruction register and field decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [3:0]  Cond,
    output logic [1:0]  Op,
    output logic [5:0]  Funct,
    output logic [3:0]  Rn,
    output logic [3:0]  Rd,
    output logic [3:0]  Rm,
    output logic [31:0] PCPlus8,
    output logic [31:0] retired_cnt,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] retired_q, retired_d;
    logic        misalign_q, misalign_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            retired_q  <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            retired_q  <= retired_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        retired_d  = retired_q;
        misalign_d = misalign_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    // Branch targets are word-aligned by dropping Result[1:0]; the drop is flagged.
                    if (PCSrc) begin
                        pc_d = {Result[31:2], 2'b00};
                        if (Result[1:0] != 2'b00) misalign_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'(PC_STEP);
                    end
                    retired_d = retired_q + 32'd1;
                    valid_d   = 1'b0;
                    state_d   = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request is decoded from state so it falls as soon as reset clears the state register.
    assign imem_req     = (state_q == ST_REQ);
    assign imem_addr    = pc_q;
    assign instr_valid  = valid_q;
    assign Instr        = instr_q;
    assign Cond         = instr_q[31:28];
    assign Op           = instr_q[27:26];
    assign Funct        = instr_q[25:20];
    assign Rn           = instr_q[19:16];
    assign Rd           = instr_q[15:12];
    assign Rm           = instr_q[3:0];
    assign PCPlus8      = pc_q + 32'd8;
    assign retired_cnt  = retired_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_ready = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] Result = 32'h0;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [3:0]  Cond;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rn;
    logic [3:0]  Rd;
    logic [3:0]  Rm;
    logic [31:0] PCPlus8;
    logic [31:0] retired_cnt;
    logic        misalign_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;
    logic [31:0] held;

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_ready(instr_ready), .PCSrc(PCSrc), .Result(Result),
        .instr_valid(instr_valid), .Instr(Instr),
        .Cond(Cond), .Op(Op), .Funct(Funct), .Rn(Rn), .Rd(Rd), .Rm(Rm),
        .PCPlus8(PCPlus8), .retired_cnt(retired_cnt), .misalign_err(misalign_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word on the memory bus for one edge and record it as expected output.
    task automatic fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        exp_q.push_back(word);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic expect_instr(input string tag);
        int budget = 4;
        while (!instr_valid && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            exp_word = exp_q.pop_front();
            chk({tag, "_instr"}, Instr, exp_word);
            chk({tag, "_cond"}, {28'h0, Cond}, {28'h0, exp_word[31:28]});
            chk({tag, "_rm"}, {28'h0, Rm}, {28'h0, exp_word[3:0]});
        end
    endtask

    task automatic retire(input logic src, input logic [31:0] res);
        instr_ready = 1'b1;
        PCSrc       = src;
        Result      = res;
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        Result      = 32'h0;
    endtask

    initial begin
        // T1 reset
        for (int i = 0; i < 3; i++) tick();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_cnt", retired_cnt, 32'h0);
        chk("rst_mis", {31'h0, misalign_err}, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        RST_N = 1'b1;
        tick();
        chk("t1_req", {31'h0, imem_req}, 32'h1);
        chk("t1_addr", imem_addr, 32'h0);

        // T2 three wait cycles then ack
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_wait_addr", imem_addr, 32'h0);
            chk("t2_wait_req", {31'h0, imem_req}, 32'h1);
        end
        fetch(32'hE283_3000);
        expect_instr("t2");
        chk("t2_op", {30'h0, Op}, 32'h0);
        chk("t2_funct", {26'h0, Funct}, 32'h28);
        chk("t2_rn", {28'h0, Rn}, 32'h3);
        chk("t2_rd", {28'h0, Rd}, 32'h3);
        chk("t2_pc8", PCPlus8, 32'h8);
        chk("t2_req_low", {31'h0, imem_req}, 32'h0);

        // T3 sequential retire
        retire(1'b0, 32'h0);
        chk("t3_valid", {31'h0, instr_valid}, 32'h0);
        chk("t3_cnt", retired_cnt, 32'h1);
        chk("t3_addr", imem_addr, 32'h4);
        chk("t3_req", {31'h0, imem_req}, 32'h1);

        // T4 misaligned branch
        fetch(32'hEA00_0010);
        expect_instr("t4");
        chk("t4_pc8", PCPlus8, 32'hC);
        retire(1'b1, 32'h102);
        chk("t4_addr", imem_addr, 32'h100);
        chk("t4_mis", {31'h0, misalign_err}, 32'h1);
        chk("t4_cnt", retired_cnt, 32'h2);

        // T5 hold with toggling ack
        fetch(32'h1234_5678);
        expect_instr("t5");
        held = Instr;
        for (int i = 0; i < 5; i++) begin
            imem_ack   = ~imem_ack;
            imem_rdata = $urandom;
            tick();
            chk("t5_instr", Instr, held);
            chk("t5_addr", imem_addr, 32'h100);
            chk("t5_req", {31'h0, imem_req}, 32'h0);
            chk("t5_rd", {28'h0, Rd}, 32'h5);
        end
        imem_ack = 1'b0;
        retire(1'b0, 32'h3);
        chk("t5_addr_next", imem_addr, 32'h104);
        chk("t5_mis_sticky", {31'h0, misalign_err}, 32'h1);
        chk("t5_cnt", retired_cnt, 32'h3);

        // wrap at the top of the address space
        fetch(32'hEAFF_FFFE);
        expect_instr("wrap_a");
        retire(1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'hE1A0_0001);
        expect_instr("wrap_b");
        chk("wrap_pc8", PCPlus8, 32'h4);
        retire(1'b0, 32'h0);
        chk("wrap_seq", imem_addr, 32'h0);

        // T6 async reset during a REQ wait, stale ack across release
        tick();
        RST_N = 1'b0;
        #1;
        chk("t6_req_async", {31'h0, imem_req}, 32'h0);
        chk("t6_cnt_async", retired_cnt, 32'h0);
        chk("t6_mis_async", {31'h0, misalign_err}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        chk("t6_stale_valid", {31'h0, instr_valid}, 32'h0);
        chk("t6_restart_addr", imem_addr, 32'h0);
        chk("t6_restart_req", {31'h0, imem_req}, 32'h1);
        imem_ack = 1'b0;
        tick();
        fetch(32'hE080_2001);
        expect_instr("t6");
        chk("t6_rn", {28'h0, Rn}, 32'h0);
        chk("t6_rd", {28'h0, Rd}, 32'h2);
        chk("t6_sb_drained", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
